ahb_decoder_stage_param: RTL

Parametrised AHB bus-matrix decoder stage for one input port. It generalises the fixed 4-output decoder to NUM_PORTS outputs, each with a parameter-defined address window. It contains an integrated two-cycle ERROR default slave and a sticky decode-error capture and counter block. It sits between an input stage and the NUM_PORTS output stages of the bus matrix.

---
 rtl/ahb_decoder_stage_param.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ahb_decoder_stage_param.sv
// AHB bus-matrix decoder stage for one input port: NUM_PORTS address windows,
// integrated two-cycle ERROR default slave, sticky decode-error capture/counter.

module ahb_dec_region #(
   parameter logic [21:0] BASE_V  = 22'h0,
   parameter logic [21:0] LIMIT_V = 22'h0
) (
   input  logic [21:0] addr_i,
   output logic        hit_o
);
   assign hit_o = (addr_i >= BASE_V) && (addr_i <= LIMIT_V);
endmodule

module ahb_decoder_stage_param #(
   parameter int                      NUM_PORTS = 4,
   parameter logic [NUM_PORTS*22-1:0] BASE      = {22'h100040, 22'h100000, 22'h080000, 22'h000000},
   parameter logic [NUM_PORTS*22-1:0] LIMIT     = {22'h100043, 22'h10000b, 22'h0803ff, 22'h0003ff},
   parameter int                      CNT_W     = 8
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic                      HREADYS,
   input  logic                      sel_dec,
   input  logic [21:0]               decode_addr_dec,
   input  logic [1:0]                trans_dec,
   input  logic [NUM_PORTS-1:0]      active_in,
   input  logic [NUM_PORTS-1:0]      readyout_in,
   input  logic [2*NUM_PORTS-1:0]    resp_in,
   input  logic [32*NUM_PORTS-1:0]   rdata_in,
   input  logic [32*NUM_PORTS-1:0]   ruser_in,
   input  logic                      err_clr,
   output logic [NUM_PORTS-1:0]      sel_out,
   output logic                      active_dec,
   output logic                      HREADYOUTS,
   output logic [1:0]                HRESPS,
   output logic [31:0]               HRDATAS,
   output logic [31:0]               HRUSERS,
   output logic                      err_valid,
   output logic [21:0]               err_addr,
   output logic [CNT_W-1:0]          err_count
);
   localparam int             PW       = $clog2(NUM_PORTS + 1);
   localparam logic [PW-1:0]  DEF_PORT = PW'(NUM_PORTS);
   localparam logic [1:0]     TR_IDLE  = 2'b00;
   localparam logic [1:0]     RSP_OKAY = 2'b00;
   localparam logic [1:0]     RSP_ERR  = 2'b01;

   typedef enum logic [1:0] {DS_IDLE = 2'd0, DS_ERR1 = 2'd1, DS_ERR2 = 2'd2} ds_state_e;

   logic [NUM_PORTS-1:0] hit;
   logic [PW-1:0]        addr_port;
   logic [PW-1:0]        data_port_q, data_port_d;
   ds_state_e            state_q, state_d;
   logic                 ds_ready;
   logic [1:0]           ds_resp;
   logic                 unmapped_acc;
   logic                 err_valid_q, err_valid_d;
   logic [21:0]          err_addr_q, err_addr_d;
   logic [CNT_W-1:0]     err_count_q, err_count_d;

   genvar g;
   generate
      for (g = 0; g < NUM_PORTS; g++) begin : g_region
         ahb_dec_region #(
            .BASE_V  (BASE[22*g +: 22]),
            .LIMIT_V (LIMIT[22*g +: 22])
         ) u_region (
            .addr_i (decode_addr_dec),
            .hit_o  (hit[g])
         );
      end
   endgenerate

   // Descending scan so the lowest matching index wins on overlap; IDLE keeps
   // the previous data-phase port so HSEL does not bounce between transfers.
   always_comb begin
      addr_port = DEF_PORT;
      for (int i = NUM_PORTS - 1; i >= 0; i--)
         if (hit[i]) addr_port = PW'(i);
      if (trans_dec == TR_IDLE) addr_port = data_port_q;
   end

   always_comb begin
      sel_out    = '0;
      active_dec = 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (addr_port == PW'(i)) begin
            sel_out[i] = sel_dec;
            active_dec = active_in[i];
         end
      end
   end

   assign data_port_d = HREADYS ? addr_port : data_port_q;

   // Any data_port outside 0..NUM_PORTS-1 falls through to the default slave.
   always_comb begin
      HREADYOUTS = ds_ready;
      HRESPS     = ds_resp;
      HRDATAS    = '0;
      HRUSERS    = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (data_port_q == PW'(i)) begin
            HREADYOUTS = readyout_in[i];
            HRESPS     = resp_in[2*i +: 2];
            HRDATAS    = rdata_in[32*i +: 32];
            HRUSERS    = ruser_in[32*i +: 32];
         end
      end
   end

   assign unmapped_acc = sel_dec & HREADYS & trans_dec[1] & (addr_port == DEF_PORT);

   always_comb begin
      state_d  = state_q;
      ds_ready = 1'b1;
      ds_resp  = RSP_OKAY;
      case (state_q)
         DS_IDLE: if (unmapped_acc) state_d = DS_ERR1;
         DS_ERR1: begin
            ds_ready = 1'b0;
            ds_resp  = RSP_ERR;
            state_d  = DS_ERR2;
         end
         DS_ERR2: begin
            ds_resp = RSP_ERR;
            state_d = unmapped_acc ? DS_ERR1 : DS_IDLE;
         end
         default: state_d = DS_IDLE;
      endcase
   end

   // A clear coinciding with an event leaves the event recorded as the first.
   always_comb begin
      err_valid_d = err_valid_q;
      err_addr_d  = err_addr_q;
      err_count_d = err_count_q;
      if (err_clr) begin
         err_valid_d = 1'b0;
         err_addr_d  = '0;
         err_count_d = '0;
      end
      if (unmapped_acc) begin
         if (!err_valid_q || err_clr) begin
            err_valid_d = 1'b1;
            err_addr_d  = decode_addr_dec;
         end
         if (err_clr)            err_count_d = CNT_W'(1);
         else if (!(&err_count_q)) err_count_d = err_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         data_port_q <= '0;
         state_q     <= DS_IDLE;
         err_valid_q <= 1'b0;
         err_addr_q  <= '0;
         err_count_q <= '0;
      end else begin
         data_port_q <= data_port_d;
         state_q     <= state_d;
         err_valid_q <= err_valid_d;
         err_addr_q  <= err_addr_d;
         err_count_q <= err_count_d;
      end
   end

   assign err_valid = err_valid_q;
   assign err_addr  = err_addr_q;
   assign err_count = err_count_q;

endmodule
